// File: rtl/vmem_rect_fill.sv
// Rectangle-fill write engine for the tile video memory: clips a fill command
// to the visible COLS x ROWS area and streams one raster-order write per clock.
module vmem_rect_fill #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 15
) (
  input  logic              clkb,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clear,
  input  logic [6:0]        cmd_x,
  input  logic [5:0]        cmd_y,
  input  logic [6:0]        cmd_w,
  input  logic [5:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_web,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_e;

  localparam logic [7:0] ColsW = 8'(COLS);
  localparam logic [6:0] RowsW = 7'(ROWS);

  state_e            state_q, state_d;
  logic [6:0]        cmdX_q, cmdX_d;
  logic [5:0]        cmdY_q, cmdY_d;
  logic [7:0]        cmdW_q, cmdW_d;
  logic [6:0]        cmdH_q, cmdH_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic [7:0]        xEnd_q, xEnd_d;
  logic [6:0]        yEnd_q, yEnd_d;
  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              web_q, web_d;

  logic [7:0]        xSum;
  logic [6:0]        ySum;
  logic              areaEmpty;
  logic              colLast;
  logic              rowLast;

  // Widened sums cannot wrap: x+w tops out at 255 and y+h at 127.
  always_comb begin
    xSum      = {1'b0, cmdX_q} + cmdW_q;
    ySum      = {1'b0, cmdY_q} + cmdH_q;
    areaEmpty = (cmdW_q == 8'd0) || (cmdH_q == 7'd0) ||
                ({1'b0, cmdX_q} >= ColsW) || ({1'b0, cmdY_q} >= RowsW);
    colLast   = (({1'b0, col_q} + 8'd1) == xEnd_q);
    rowLast   = (({1'b0, row_q} + 7'd1) == yEnd_q);
  end

  always_comb begin
    state_d = state_q;
    cmdX_d  = cmdX_q;
    cmdY_d  = cmdY_q;
    cmdW_d  = cmdW_q;
    cmdH_d  = cmdH_q;
    color_d = color_q;
    xEnd_d  = xEnd_q;
    yEnd_d  = yEnd_q;
    col_d   = col_q;
    row_d   = row_q;
    wdata_d = wdata_q;
    web_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmdX_d  = cmd_clear ? 7'd0  : cmd_x;
          cmdY_d  = cmd_clear ? 6'd0  : cmd_y;
          cmdW_d  = cmd_clear ? ColsW : {1'b0, cmd_w};
          cmdH_d  = cmd_clear ? RowsW : {1'b0, cmd_h};
          color_d = cmd_color;
          state_d = CLIP;
        end
      end
      CLIP: begin
        xEnd_d = (xSum > ColsW) ? ColsW : xSum;
        yEnd_d = (ySum > RowsW) ? RowsW : ySum;
        if (areaEmpty) begin
          state_d = DONE;
        end else begin
          // The first write is issued here so it is on the port one cycle later.
          col_d   = cmdX_q;
          row_d   = cmdY_q;
          wdata_d = color_q;
          web_d   = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (colLast && rowLast) begin
          state_d = DONE;
        end else begin
          web_d = 1'b1;
          if (colLast) begin
            col_d = cmdX_q;
            row_d = row_q + 6'd1;
          end else begin
            col_d = col_q + 7'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clkb) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmdX_q  <= '0;
      cmdY_q  <= '0;
      cmdW_q  <= '0;
      cmdH_q  <= '0;
      color_q <= '0;
      xEnd_q  <= '0;
      yEnd_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wdata_q <= '0;
      web_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmdX_q  <= cmdX_d;
      cmdY_q  <= cmdY_d;
      cmdW_q  <= cmdW_d;
      cmdH_q  <= cmdH_d;
      color_q <= color_d;
      xEnd_q  <= xEnd_d;
      yEnd_q  <= yEnd_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wdata_q <= wdata_d;
      web_q   <= web_d;
    end
  end

  // Address and data only move together with a write, so they hold otherwise.
  assign mem_waddr = ADDR_W'({row_q, col_q});
  assign mem_wdata = wdata_q;
  assign mem_web   = web_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
